vga_timing: RTL
===============

// Module: vga_timing
// PURPOSE
//  Display-side timing generator feeding the memory/video block: produces raster coordinates
//  (pixel_x, pixel_y) for the tilemap/framebuffer lookup, captures the returned 12-bit RGB
//  pixel, and drives the VGA pins (4:4:4 RGB, hsync, vsync). Also raises a one-cycle
//  vblank pulse, routed to the interrupt controller for tear-free framebuffer updates.
// PARAMETERS
//  PIX_DIV   4    clk cycles per pixel period (100 MHz -> 25 MHz); must be >= PIPE_LAT+1
//  PIPE_LAT  2    clk cycles from pixel_x/y change to valid pixel input
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixel periods)
//  H_SYNC    96   hsync pulse width (pixel periods)
//  H_BP      48   horizontal back porch (pixel periods)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch (lines)
// PORTS
//  clk        in   1   system clock, single domain
//  rst_n      in   1   asynchronous active-low reset
//  pixel_x    out  10  current raster column h_cnt (0..H_TOTAL-1)
//  pixel_y    out  10  current raster line v_cnt (0..V_TOTAL-1)
//  pixel      in   12  RGB {r[11:8],g[7:4],b[3:0]} for pixel_x/pixel_y, valid PIPE_LAT clks after change
//  vga_r      out  4   red
//  vga_g      out  4   green
//  vga_b      out  4   blue
//  vga_hsync  out  1   horizontal sync, active low
//  vga_vsync  out  1   vertical sync, active low
//  vblank_irq out  1   one-clk pulse at start of vertical blank
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
//  - Reset (async, rst_n=0): div_cnt=0, h_cnt=0, v_cnt=0, vga_r/g/b=0, hsync=1, vsync=1,
//    vblank_irq=0. Takes effect immediately mid-frame; the first tick comes PIX_DIV clks after release.
//  - Divider: div_cnt counts 0..PIX_DIV-1 and wraps; tick = (div_cnt == PIX_DIV-1).
//  - On tick, in the same clk edge:
//    - Capture stage: active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
//      {vga_r,vga_g,vga_b} <= active ? pixel : 12'h000.
//      vga_hsync <= !(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]).
//      vga_vsync <= !(v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]).
//    - Advance: if h_cnt == H_TOTAL-1, h_cnt <= 0 and v_cnt <= (v_cnt == V_TOTAL-1) ? 0 : v_cnt+1;
//      else h_cnt <= h_cnt+1.
//  - Pins therefore lag the coordinates by exactly one pixel period, with RGB and syncs aligned.
//  - Because PIX_DIV > PIPE_LAT, pixel is always sampled after the downstream 2-stage lookup
//    has settled. An elaboration check fails if PIX_DIV <= PIPE_LAT.
//  - pixel_x/pixel_y are driven straight from registered h_cnt/v_cnt (no combinational path)
//    and are stable for PIX_DIV clks.
//  - vblank_irq = 1 for exactly one clk: on the tick where h_cnt wraps to 0 and v_cnt becomes
//    V_ACTIVE. It is 0 at all other times, including the reset-release cycle.
//  - Blanking: RGB is forced to 0 outside the active region regardless of pixel (for example,
//    scroll wrap-around garbage).
//  - Widths: counters are 10 bits (799 < 1024); all compares are unsigned, with no overflow
//    paths.
// STRUCTURE
//  - Shared package vga_pkg holds the 640x480@60 timing localparams (H_*/V_*, totals, sync
//    start/end) and a typedef rgb12_t. The same constants are used by software-visible
//    scroll/scale logic.
//  - One natural sub-module, vga_pix_tick: a parameterised PIX_DIV divider producing tick,
//    with async active-low reset.
//  - Counters, capture registers and irq logic stay in vga_timing.
// TESTING
//  1 Reset, then release -> hsync=vsync=1, rgb=0, pixel_x=pixel_y=0; first h_cnt increment
//    exactly 4 clks after release.
//  2 Free-run one line -> vga_hsync low for 96 ticks, starting at the tick capturing h=656;
//    line period 3200 clks; pixel_x wraps 799->0 and pixel_y increments.
//  3 Free-run one frame -> vga_vsync low for 2 lines (v=490,491); frame period 1,680,000 clks;
//    v 524->0 wrap.
//  4 Drive pixel = 12'hABC with 2-clk latency model of the lookup -> vga_r/g/b = A/B/C one
//    pixel period after (x,y) is presented; at x=640, y=0, rgb = 0 despite pixel = ABC.
//  5 Count vblank_irq -> exactly one 1-clk pulse per frame, coincident with pixel_y becoming
//    480 and pixel_x = 0.
//  6 Assert rst_n mid-line at h=300, v=200 -> all outputs return to reset values
//    asynchronously (same timestep); after release, timing restarts from (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// 640x480@60 raster timing constants and shared types for the display path.
// Consumed by the timing generator and by the software-visible scroll/scale logic.
package vga_pkg;

  localparam int unsigned CNT_W    = 10;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [11:0]      rgb12_t;

endpackage

// File: rtl/vga_timing_if.sv
// Raster coordinate / pixel return / VGA pin bundle between timing generator and video side.
// master = timing generator; slave = framebuffer lookup + pin consumer.
interface vga_timing_if;
  import vga_pkg::*;

  cnt_t       pixel_x;
  cnt_t       pixel_y;
  rgb12_t     pixel;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       vblank_irq;

  modport master (
    output pixel_x, pixel_y, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vblank_irq,
    input  pixel
  );

  modport slave (
    input  pixel_x, pixel_y, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vblank_irq,
    output pixel
  );

endinterface

// File: rtl/vga_pix_tick.sv
// Pixel-rate divider: one-clk tick every PIX_DIV clks, first tick PIX_DIV clks after reset.
// Free-running, no backpressure.
module vga_pix_tick #(
  parameter int unsigned PIX_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(PIX_DIV - 1);

  logic [DW-1:0] div_cnt;

  assign tick = (div_cnt == DIV_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster generator: coordinates out, returned pixel captured to pins one pixel period later.
// Free-running with no backpressure; vblank_irq is a single-clk pulse.
module vga_timing #(
  parameter int unsigned PIX_DIV  = 4,
  parameter int unsigned PIPE_LAT = 2,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP
) (
  input  logic          clk,
  input  logic          rst_n,
  vga_timing_if.master  vif
);
  import vga_pkg::*;

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST   = cnt_t'(H_TOT - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOT - 1);
  localparam cnt_t H_ACT_C  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT_C  = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_FIRST = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_LAST  = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam cnt_t VS_FIRST = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_LAST  = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  // Line whose wrap enters vertical blank.
  localparam cnt_t V_IRQ_LN = cnt_t'(V_ACTIVE - 1);

  if (PIX_DIV <= PIPE_LAT) begin : g_bad_div
    $error("vga_timing: PIX_DIV must exceed PIPE_LAT so the lookup settles before capture");
  end
  if (H_TOT > (1 << CNT_W) || V_TOT > (1 << CNT_W)) begin : g_bad_cnt
    $error("vga_timing: raster totals exceed counter width");
  end

  logic   tick;
  cnt_t   h_cnt;
  cnt_t   v_cnt;
  rgb12_t rgb_q;
  logic   hsync_q;
  logic   vsync_q;
  logic   irq_q;
  logic   active;
  logic   hs_on;
  logic   vs_on;

  vga_pix_tick #(.PIX_DIV(PIX_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs_on  = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs_on  = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (tick) begin
        // Blanking masks whatever the lookup returns outside the visible window.
        rgb_q   <= active ? vif.pixel : '0;
        hsync_q <= !hs_on;
        vsync_q <= !vs_on;
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
          irq_q <= (v_cnt == V_IRQ_LN);
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign vif.pixel_x    = h_cnt;
  assign vif.pixel_y    = v_cnt;
  assign vif.vga_r      = rgb_q[11:8];
  assign vif.vga_g      = rgb_q[7:4];
  assign vif.vga_b      = rgb_q[3:0];
  assign vif.vga_hsync  = hsync_q;
  assign vif.vga_vsync  = vsync_q;
  assign vif.vblank_irq = irq_q;

endmodule
